// File: rtl/vic20_clk_pkg.sv
// Shared types and default constants for the VIC-20 clock-enable / reset generator.
// Holds the reset FSM encoding, the 25 MHz divisor/phase tables and the tick counter width.
package vic20_clk_pkg;

  typedef enum logic [1:0] {
    S_POR     = 2'd0,
    S_RUN     = 2'd1,
    S_BTN     = 2'd2,
    S_STRETCH = 2'd3
  } rst_state_e;

  localparam int unsigned TICK_W     = 16;
  localparam int unsigned DEF_NUM_CH = 3;
  localparam int unsigned DEF_DIV_W  = 8;

  // ch0 CPU 1 MHz, ch1 VIA phase-2 1 MHz half a period later, ch2 VIA 4x ~4.17 MHz
  localparam logic [DEF_NUM_CH*DEF_DIV_W-1:0] DEF_DIVS   = {8'd6, 8'd25, 8'd25};
  localparam logic [DEF_NUM_CH*DEF_DIV_W-1:0] DEF_PHASES = {8'd0, 8'd12, 8'd0};

endpackage

// File: rtl/clken_div.sv
// One clock-enable channel: wrapping counter, phase compare and resync restart.
// DIV = 1 keeps the counter at zero, so the enable stays high every cycle.
module clken_div #(
  parameter int unsigned      DIV_W = 8,
  parameter logic [DIV_W-1:0] DIV   = DIV_W'(1),
  parameter logic [DIV_W-1:0] PHASE = DIV_W'(0)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic resync,
  output logic clken
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV - DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_clken;

  // resync restarts the channel exactly as a reset_n release would
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else if (resync) begin
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == DIV_LAST) ? '0 : r_cnt + DIV_W'(1);
      r_clken <= (r_cnt == PHASE);
    end
  end

  assign clken = r_clken;

endmodule

// File: rtl/clken_reset_gen.sv
// NUM_CH clock-enable generator plus power-up / button reset sequencer for the VIC-20 core.
// Define CLKEN_DEBOUNCE_EN to insert the DEB_CYCLES button debouncer after the synchroniser.
module clken_reset_gen
  import vic20_clk_pkg::*;
#(
  parameter int unsigned                  NUM_CH        = DEF_NUM_CH,
  parameter int unsigned                  DIV_W         = DEF_DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0]      DIVS          = DEF_DIVS,
  parameter logic [NUM_CH*DIV_W-1:0]      PHASES        = DEF_PHASES,
  parameter int unsigned                  POR_TICKS     = 65535,
  parameter int unsigned                  STRETCH_TICKS = 16,
  parameter int unsigned                  DEB_CYCLES    = 250000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_n,
  input  logic              resync,
  output logic [NUM_CH-1:0] clken,
  output logic              sys_reset_n,
  output logic              por_done
);

  localparam logic [TICK_W-1:0] POR_LAST     = TICK_W'(POR_TICKS - 1);
  localparam logic [TICK_W-1:0] STRETCH_LAST = TICK_W'(STRETCH_TICKS - 1);

  logic [NUM_CH-1:0] w_clken;
  logic              w_btn_pressed;
  logic              w_tick;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clken_div #(
      .DIV_W (DIV_W),
      .DIV   (DIVS[k*DIV_W +: DIV_W]),
      .PHASE (PHASES[k*DIV_W +: DIV_W])
    ) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .resync  (resync),
      .clken   (w_clken[k])
    );
  end

  assign clken = w_clken;

  logic r_sync1;
  logic r_sync2;

  // two-flop synchroniser for the asynchronous button, idles at "released"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CLKEN_DEBOUNCE_EN
  localparam int unsigned       DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_deb_level;

  // new level is accepted on the DEB_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b1;
    end else if (r_sync2 == r_deb_level) begin
      r_deb_cnt   <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_deb_cnt   <= '0;
      r_deb_level <= r_sync2;
    end else begin
      r_deb_cnt   <= r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_btn_pressed = ~r_deb_level;
`else
  assign w_btn_pressed = ~r_sync2;
`endif

  // a channel-0 tick that coincides with resync is discarded
  assign w_tick = w_clken[0] & ~resync;

  rst_state_e        r_state;
  rst_state_e        w_next;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_next;
  logic              r_por_done;
  logic              w_por_next;
  logic              r_sys_reset_n;

  always_comb begin
    w_next      = r_state;
    w_tick_next = r_tick_cnt;
    w_por_next  = r_por_done;
    case (r_state)
      S_POR: begin
        if (w_tick && (r_tick_cnt == POR_LAST)) begin
          w_tick_next = '0;
          w_next      = S_RUN;
          w_por_next  = 1'b1;
        end else if (w_tick) begin
          w_tick_next = r_tick_cnt + TICK_W'(1);
        end else begin
          w_tick_next = r_tick_cnt;
        end
      end
      S_RUN: begin
        if (w_btn_pressed) begin
          w_next = S_BTN;
        end else begin
          w_next = S_RUN;
        end
      end
      S_BTN: begin
        if (w_btn_pressed) begin
          w_next = S_BTN;
        end else begin
          w_next      = S_STRETCH;
          w_tick_next = '0;
        end
      end
      S_STRETCH: begin
        if (w_btn_pressed) begin
          w_next      = S_BTN;
          w_tick_next = '0;
        end else if (w_tick && (r_tick_cnt == STRETCH_LAST)) begin
          w_next      = S_RUN;
          w_tick_next = '0;
        end else if (w_tick) begin
          w_tick_next = r_tick_cnt + TICK_W'(1);
        end else begin
          w_tick_next = r_tick_cnt;
        end
      end
      default: begin
        w_next      = S_POR;
        w_tick_next = '0;
      end
    endcase
  end

  // state register; sys_reset_n is registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_POR;
      r_tick_cnt    <= '0;
      r_por_done    <= 1'b0;
      r_sys_reset_n <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_tick_cnt    <= w_tick_next;
      r_por_done    <= w_por_next;
      r_sys_reset_n <= (w_next == S_RUN);
    end
  end

  assign sys_reset_n = r_sys_reset_n;
  assign por_done    = r_por_done;

endmodule
